queue_write_arbiter: RTL and testbench
======================================

Name: queue_write_arbiter

Overview:
- Shares the single write port of the game message queue between NUM_REQ producers (input decoder, flood-fill reveal engine, timer, score logic).
- Picks one pending requester by round-robin and latches its message.
- Drives the queue write port until the queue acknowledges, or until a timeout expires.
- Reports completion (done) or failure (drop) back to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- MSG_WIDTH, 8, width of one queue message in bits.
- TIMEOUT, 15, number of WRITE cycles without ack before the message is dropped; 0 disables the timeout (wait forever).

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  req[i] high means requester i has a message pending; held until done[i] or drop[i].
- req_data  input  NUM_REQ*MSG_WIDTH  message of requester i in bits [i*MSG_WIDTH +: MSG_WIDTH].
- done  output  NUM_REQ  one-cycle pulse on the granted requester's bit when the queue accepts its message.
- drop  output  NUM_REQ  one-cycle pulse on the granted requester's bit when its message times out.
- q_write  output  MSG_WIDTH  message to the queue write port.
- q_write_en  output  1  queue write request.
- q_write_ack  input  1  queue accepted the write this cycle.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, on any clock edge with reset=1 and from any state, including mid-WRITE:
  - state=IDLE, rr_ptr=0, cnt=0.
  - done=0, drop=0, q_write_en=0, q_write=0, busy=0.
  - An in-flight message is abandoned with no done/drop pulse.
- All outputs are registered.
- Round-robin search:
  - Starts at rr_ptr and wraps modulo NUM_REQ.
  - The first i with req[i]=1 wins.
  - rr_ptr is set to (winner+1) mod NUM_REQ whenever a transaction ends, by done or by drop.
- FSM state IDLE:
  - If req has no bits set, stay in IDLE.
  - Otherwise latch the winner index into gidx and req_data[gidx] into q_write, clear cnt, and go to WRITE.
  - The latched data is frozen for the rest of the transaction; later changes on req_data are ignored.
- FSM state WRITE:
  - q_write_en=1 and busy=1.
  - If q_write_ack=1: go to DONE and arm done[gidx].
  - Else if TIMEOUT!=0 and cnt==TIMEOUT-1: go to DONE and arm drop[gidx].
  - Else cnt <= cnt+1.
  - cnt is ceil(log2(TIMEOUT+1)) bits wide and saturates; it never wraps.
  - If q_write_ack and the timeout fall in the same cycle, the ack wins: done pulses, not drop.
- FSM state DONE:
  - q_write_en=0.
  - Exactly one of done[gidx] / drop[gidx] is high for this single cycle.
  - Update rr_ptr, then go to IDLE.
- Latency:
  - req sampled in IDLE at cycle t gives q_write_en=1 from cycle t+1.
  - An ack sampled in cycle t+k gives the done pulse in cycle t+k+1 and q_write_en=0 in that same cycle.
  - The next grant is sampled in IDLE at t+k+2.
  - Best case is one message every 3 cycles.
- q_write_ack outside WRITE is ignored.
- If req[gidx] deasserts mid-transaction, the transaction still completes and the pulse is still issued.
- A requester must drop req in the cycle after its done/drop pulse, or it is eligible to win again under round-robin order.
- Never more than one bit set in done|drop; never done and drop in the same cycle.

Test Plan:
- Single request, immediate ack:
  - Stimulus: reset, then req=0001, data0=8'h3C; queue acks in the first WRITE cycle.
  - Required: q_write=8'h3C with q_write_en high for 1 cycle; done=0001 one cycle later; busy low afterwards.
- Round-robin fairness:
  - Stimulus: req=1111 held; every requester re-asserts after its done; queue acks immediately.
  - Required: grant order 0,1,2,3,0; each done pulse is 3 cycles apart.
- Queue full then accepts:
  - Stimulus: q_write_ack low for 5 WRITE cycles, then high.
  - Required: q_write_en high for 6 consecutive cycles; q_write stable the whole time; done fires and drop does not.
- Timeout:
  - Stimulus: TIMEOUT=15, ack never asserted.
  - Required: after 15 WRITE cycles drop[gidx] pulses; rr_ptr advances to the next requester.
  - Repeat with TIMEOUT=0: q_write_en stays high indefinitely and no drop occurs.
- Simultaneous ack and timeout:
  - Stimulus: ack on WRITE cycle 15 with TIMEOUT=15.
  - Required: done pulses and drop stays 0.
- Reset mid-WRITE:
  - Stimulus: assert reset while q_write_en=1.
  - Required: next cycle all outputs are 0 and state is IDLE; with req=1010 the next grant goes to requester 1.

Source files
------------

// File: rtl/queue_write_arbiter_if.sv
// Producer/queue side signals of the message queue write arbiter.
// master = arbiter, slave = producers plus queue write port.
interface queue_write_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MSG_WIDTH = 8
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*MSG_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           done;
    logic [NUM_REQ-1:0]           drop;
    logic [MSG_WIDTH-1:0]         q_write;
    logic                         q_write_en;
    logic                         q_write_ack;

    modport master (
        input  req, req_data, q_write_ack,
        output done, drop, q_write, q_write_en
    );

    modport slave (
        output req, req_data, q_write_ack,
        input  done, drop, q_write, q_write_en
    );
endinterface

// File: rtl/queue_write_arbiter.sv
// Round-robin arbiter sharing the game message queue write port between
// NUM_REQ producers, with optional ack timeout and done/drop reporting.
module queue_write_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MSG_WIDTH = 8,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    queue_write_arbiter_if.master  bus,
    output logic                   busy
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MSG_WIDTH-1:0] q_write_q, q_write_d;
    logic                 q_write_en_q, q_write_en_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   drop_q, drop_d;
    logic                 busy_q, busy_d;

    logic [MSG_WIDTH-1:0] msg [NUM_REQ];
    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_msg
        assign msg[g] = bus.req_data[g*MSG_WIDTH +: MSG_WIDTH];
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr_q) + 32'(i)) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gidx_d       = gidx_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        q_write_d    = q_write_q;
        q_write_en_d = 1'b0;
        done_d       = '0;
        drop_d       = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d       = win_idx;
                    q_write_d    = msg[win_idx];
                    cnt_d        = '0;
                    q_write_en_d = 1'b1;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                // Ack has priority over a timeout expiring in the same cycle.
                if (bus.q_write_ack) begin
                    done_d[gidx_q] = 1'b1;
                    state_d        = DONE;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    drop_d[gidx_q] = 1'b1;
                    state_d        = DONE;
                end else begin
                    q_write_en_d = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                rr_ptr_d = (gidx_q == IDX_LAST) ? '0 : gidx_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            gidx_q       <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            q_write_q    <= '0;
            q_write_en_q <= 1'b0;
            done_q       <= '0;
            drop_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gidx_q       <= gidx_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            q_write_q    <= q_write_d;
            q_write_en_q <= q_write_en_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.done       = done_q;
    assign bus.drop       = drop_q;
    assign bus.q_write    = q_write_q;
    assign bus.q_write_en = q_write_en_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_queue_write_arbiter.sv
// Scoreboard bench for queue_write_arbiter: stimulus pushes expected
// completions, a monitor pops them when done/drop pulses.
module tb_queue_write_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned MW = 8;

    logic clock = 1'b0;
    logic reset;
    logic busy, busy_nt;

    queue_write_arbiter_if #(.NUM_REQ(NR), .MSG_WIDTH(MW)) bus ();
    queue_write_arbiter_if #(.NUM_REQ(NR), .MSG_WIDTH(MW)) bus_nt ();

    queue_write_arbiter #(.NUM_REQ(NR), .MSG_WIDTH(MW), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .bus(bus.master), .busy(busy)
    );

    queue_write_arbiter #(.NUM_REQ(NR), .MSG_WIDTH(MW), .TIMEOUT(0)) dut_nt (
        .clock(clock), .reset(reset), .bus(bus_nt.master), .busy(busy_nt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [NR-1:0] done;
        logic [NR-1:0] drop;
        logic [MW-1:0] data;
        int            cyc;
        int            wlen;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   checks    = 0;
    int   failures  = 0;
    int   ack_delay = -1;
    bit   stray_ack = 1'b0;
    int   qwc       = 0;
    int   wcnt      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int k);
        repeat (k) @(negedge clock);
    endtask

    task automatic expect_txn(input logic [NR-1:0] d, input logic [NR-1:0] dr,
                              input logic [MW-1:0] data, input int at, input int wlen);
        exp_t e;
        e.done = d; e.drop = dr; e.data = data; e.cyc = at; e.wlen = wlen;
        sb.push_back(e);
    endtask

    task automatic set_data(input int i, input logic [MW-1:0] v);
        bus.req_data[i*MW +: MW] = v;
    endtask

    // Queue model: ack after ack_delay stalled WRITE cycles, never if negative.
    always @(negedge clock) begin
        if (bus.q_write_en) begin
            bus.q_write_ack = (ack_delay >= 0 && qwc == ack_delay);
            qwc++;
        end else begin
            bus.q_write_ack = stray_ack;
            qwc = 0;
        end
    end

    // Monitor: checks the write port against the head entry and pops on each pulse.
    always @(negedge clock) begin
        if ((bus.done | bus.drop) != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'(bus.done | bus.drop), 32'd0);
            end else begin
                e_mon = sb.pop_front();
                chk("done_vec", 32'(bus.done), 32'(e_mon.done));
                chk("drop_vec", 32'(bus.drop), 32'(e_mon.drop));
                chk("pulse_cycle", 32'(cyc), 32'(e_mon.cyc));
                chk("write_len", 32'(wcnt), 32'(e_mon.wlen));
                chk("q_write_at_pulse", 32'(bus.q_write), 32'(e_mon.data));
                chk("en_low_at_pulse", 32'(bus.q_write_en), 32'd0);
            end
            wcnt = 0;
        end else if (bus.q_write_en) begin
            wcnt++;
            if (sb.size() == 0) chk("en_without_txn", 32'd1, 32'd0);
            else chk("q_write_stable", 32'(bus.q_write), 32'(sb[0].data));
        end else begin
            wcnt = 0;
        end
    end

    int n;

    initial begin
        reset = 1'b1;
        bus.req = '0; bus.req_data = '0; bus.q_write_ack = 1'b0;
        bus_nt.req = '0; bus_nt.req_data = '0; bus_nt.q_write_ack = 1'b0;
        wait_cyc(2);
        chk("rst_en", 32'(bus.q_write_en), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_drop", 32'(bus.drop), 32'd0);
        chk("rst_q_write", 32'(bus.q_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Single request, immediate ack.
        ack_delay = 0;
        set_data(0, 8'h3C);
        bus.req = 4'b0001;
        n = cyc;
        expect_txn(4'b0001, 4'b0000, 8'h3C, n + 2, 1);
        wait_cyc(1);
        chk("t1_en_high", 32'(bus.q_write_en), 32'd1);
        chk("t1_busy_high", 32'(busy), 32'd1);
        wait_cyc(1);
        bus.req = '0;
        chk("t1_en_low", 32'(bus.q_write_en), 32'd0);
        wait_cyc(1);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // Round-robin with all requesters held: order 0,1,2,3,0 every 3 cycles.
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_data(i, MW'(8'h10 + i));
        bus.req = 4'b1111;
        n = cyc;
        for (int k = 0; k < 5; k++)
            expect_txn(NR'(1 << (k % 4)), 4'b0000, MW'(8'h10 + (k % 4)), n + 2 + 3 * k, 1);
        wait_cyc(13);
        bus.req = '0;
        wait_cyc(3);

        // Queue full for 5 cycles; data change and req drop mid-write are ignored.
        ack_delay = 5;
        set_data(3, 8'hA5);
        bus.req = 4'b1000;
        n = cyc;
        expect_txn(4'b1000, 4'b0000, 8'hA5, n + 7, 6);
        wait_cyc(2);
        set_data(3, 8'hFF);
        bus.req = '0;
        wait_cyc(6);

        // Timeout drops requester 0, then requester 1 wins despite 0 still asking.
        ack_delay = -1;
        set_data(0, 8'h5A);
        set_data(1, 8'h6B);
        bus.req = 4'b0011;
        n = cyc;
        expect_txn(4'b0000, 4'b0001, 8'h5A, n + 16, 15);
        expect_txn(4'b0010, 4'b0000, 8'h6B, n + 19, 1);
        wait_cyc(16);
        ack_delay = 0;
        wait_cyc(2);
        bus.req = '0;
        wait_cyc(2);

        // Ack on the 15th WRITE cycle coincides with the timeout; ack wins.
        ack_delay = 14;
        set_data(2, 8'hC3);
        bus.req = 4'b0100;
        n = cyc;
        expect_txn(4'b0100, 4'b0000, 8'hC3, n + 16, 15);
        wait_cyc(16);
        bus.req = '0;
        wait_cyc(1);

        // Ack outside WRITE is ignored.
        stray_ack = 1'b1;
        wait_cyc(4);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_en", 32'(bus.q_write_en), 32'd0);
        stray_ack = 1'b0;
        wait_cyc(1);

        // Reset mid-WRITE abandons the message; rr_ptr returns to 0.
        ack_delay = -1;
        set_data(0, 8'h77);
        bus.req = 4'b0001;
        n = cyc;
        expect_txn(4'b0001, 4'b0000, 8'h77, 0, 0);
        wait_cyc(3);
        chk("t7_en_before_reset", 32'(bus.q_write_en), 32'd1);
        reset = 1'b1;
        set_data(1, 8'h99);
        set_data(3, 8'hEE);
        bus.req = 4'b1010;
        wait_cyc(1);
        chk("t7_rst_en", 32'(bus.q_write_en), 32'd0);
        chk("t7_rst_done", 32'(bus.done), 32'd0);
        chk("t7_rst_drop", 32'(bus.drop), 32'd0);
        chk("t7_rst_q_write", 32'(bus.q_write), 32'd0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        void'(sb.pop_front());
        reset = 1'b0;
        ack_delay = 0;
        n = cyc;
        expect_txn(4'b0010, 4'b0000, 8'h99, n + 2, 1);
        wait_cyc(2);
        bus.req = '0;
        wait_cyc(2);

        // TIMEOUT=0 instance waits forever without dropping.
        bus_nt.req_data[7:0] = 8'h42;
        bus_nt.req = 4'b0001;
        wait_cyc(1);
        chk("nt_q_write", 32'(bus_nt.q_write), 32'h42);
        for (int i = 0; i < 40; i++) begin
            chk("nt_en_high", 32'(bus_nt.q_write_en), 32'd1);
            chk("nt_no_pulse", 32'(bus_nt.done | bus_nt.drop), 32'd0);
            wait_cyc(1);
        end
        chk("nt_busy", 32'(busy_nt), 32'd1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) wait_cyc(1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
